// File: rtl/deser_32b_if.sv
// Serial-in / word-out bundle between the bit source and the deserializer.
// Latency: none (wires only).
// Backpressure: none; the source qualifies each bit with bit_valid, the sink always accepts.
interface deser_32b_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic              bit_in;
    logic              bit_valid;
    logic              frame_start;
    logic [0:WIDTH-1]  word_out;
    logic              word_valid;
    logic              busy;
    logic [CW-1:0]     bit_count;

    // Bit source side: drives the serial stream, observes the assembled word.
    modport master (
        output bit_in,
        output bit_valid,
        output frame_start,
        input  word_out,
        input  word_valid,
        input  busy,
        input  bit_count
    );

    // Deserializer side.
    modport slave (
        input  bit_in,
        input  bit_valid,
        input  frame_start,
        output word_out,
        output word_valid,
        output busy,
        output bit_count
    );
endinterface

// File: rtl/deser_32b.sv
// Bit-serial to WIDTH-bit parallel deserializer; first bit received lands at word_out[0].
// Latency: word_out/word_valid update on the edge that accepts the last bit (visible next cycle).
// Backpressure: none; every edge with bit_valid high consumes one bit, gaps hold all state.
module deser_32b #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    deser_32b_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [0:WIDTH-1] sr_q, sr_n;
    logic [0:WIDTH-1] word_q, word_n;
    logic             vld_q, vld_n;
    logic             busy_q, busy_n;

    // Shift register with the newest bit entering at the high index; after
    // WIDTH shifts the oldest bit has walked down to index 0.
    logic [0:WIDTH-1] shifted;
    logic [0:WIDTH-1] fresh;
    assign shifted = {sr_q[1:WIDTH-1], bus.bit_in};
    // A restart keeps only this cycle's bit; the rest is cleared so no stale
    // bits from the abandoned word linger in the register.
    assign fresh   = {{(WIDTH-1){1'b0}}, bus.bit_in};

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sr_q    <= sr_n;
            word_q  <= word_n;
            vld_q   <= vld_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state: restart, accept/complete, abort, or hold.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        sr_n    = sr_q;
        word_n  = word_q;
        vld_n   = 1'b0;

        if (bus.frame_start && bus.bit_valid) begin
            // Partial word dropped; this bit is the first of a new word.
            sr_n    = fresh;
            cnt_n   = CW'(1);
            state_n = COLLECT;
        end else if (bus.bit_valid) begin
            sr_n = shifted;
            if (cnt_q == LAST) begin
                // Last bit of the word: publish and wrap the count to zero.
                word_n  = shifted;
                vld_n   = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                cnt_n   = cnt_q + CW'(1);
                state_n = COLLECT;
            end
        end else if (bus.frame_start) begin
            // Abort without a bit: back to empty, published word untouched.
            sr_n    = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end

        busy_n = (cnt_n != '0);
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = vld_q;
    assign bus.busy       = busy_q;
    assign bus.bit_count  = cnt_q;
endmodule

// File: tb/tb_deser_32b.sv
// Self-checking bench for deser_32b: vector table, directed sequences, random stream.
// Latency: checks outputs #1 after each rising edge against a bit-queue reference.
// Backpressure: exercised through random bit_valid gaps and frame_start aborts.
module tb_deser_32b;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] data_out;

    deser_32b_if #(.WIDTH(32)) bus ();

    deser_32b #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Downstream 32-bit register fed directly by word_out.
    always_ff @(posedge clk) data_out <= bus.word_out;

    int total = 0;
    int bad   = 0;
    int npulse = 0;

    // Reference model: list of bits received so far in the current word.
    bit          q[$];
    logic [0:31] m_word = '0;
    bit          m_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit fs, input bit bv, input bit bi);
        m_pulse = 1'b0;
        if (r) begin
            q.delete();
            m_word = '0;
        end else begin
            if (fs) q.delete();
            if (bv) q.push_back(bi);
            if (q.size() == 32) begin
                for (int i = 0; i < 32; i++) m_word[i] = q[i];
                m_pulse = 1'b1;
                q.delete();
            end
        end
    endtask

    // One clock: drive, clock, update model, compare every output.
    task automatic cyc(input bit r, input bit fs, input bit bv, input bit bi);
        reset           = r;
        bus.frame_start = fs;
        bus.bit_valid   = bv;
        bus.bit_in      = bi;
        @(posedge clk);
        #1;
        model(r, fs, bv, bi);
        if (bus.word_valid) npulse++;
        chk("word_out",   bus.word_out,   m_word);
        chk("word_valid", {31'd0, bus.word_valid}, {31'd0, m_pulse});
        chk("busy",       {31'd0, bus.busy}, {31'd0, q.size() != 0});
        chk("bit_count",  {26'd0, bus.bit_count}, 32'(q.size()));
    endtask

    // Send a word index 0 first; gap_pct chance of an idle cycle before each bit.
    task automatic send_word(input logic [31:0] w, input int gap_pct);
        logic [0:31] v;
        v = w;
        for (int i = 0; i < 32; i++) begin
            while ($urandom_range(99) < gap_pct) cyc(0, 0, 0, $urandom_range(1));
            cyc(0, 0, 1, v[i]);
        end
    endtask

    typedef struct {
        bit       r, fs, bv, bi;
        bit       e_wv, e_busy;
        int       e_cnt;
    } vec_t;

    vec_t vt[11];

    initial begin
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;

        // ---- Vector table: reset and frame_start corner cases ----
        vt[0]  = '{1, 0, 1, 1, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 1, 0, 0, 0};
        vt[2]  = '{0, 0, 1, 1, 0, 1, 1};
        vt[3]  = '{0, 0, 0, 0, 0, 1, 1};
        vt[4]  = '{0, 0, 1, 0, 0, 1, 2};
        vt[5]  = '{0, 1, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 0, 0};
        vt[7]  = '{0, 1, 1, 1, 0, 1, 1};
        vt[8]  = '{0, 1, 1, 0, 0, 1, 1};
        vt[9]  = '{0, 0, 1, 1, 0, 1, 2};
        vt[10] = '{1, 0, 1, 1, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            reset           = vt[i].r;
            bus.frame_start = vt[i].fs;
            bus.bit_valid   = vt[i].bv;
            bus.bit_in      = vt[i].bi;
            @(posedge clk);
            #1;
            model(vt[i].r, vt[i].fs, vt[i].bv, vt[i].bi);
            chk("vec_word",  bus.word_out, 32'h0);
            chk("vec_valid", {31'd0, bus.word_valid}, {31'd0, vt[i].e_wv});
            chk("vec_busy",  {31'd0, bus.busy}, {31'd0, vt[i].e_busy});
            chk("vec_count", {26'd0, bus.bit_count}, 32'(vt[i].e_cnt));
        end

        // ---- Single word ----
        npulse = 0;
        send_word(32'hA5A5_0F0F, 0);
        chk("single_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("single_word", bus.word_out, 32'hA5A5_0F0F);
        cyc(0, 0, 0, 0);
        chk("single_valid_drop", {31'd0, bus.word_valid}, 32'd0);
        chk("single_pulses", 32'(npulse), 32'd1);

        // ---- Back-to-back with gaps in the second word ----
        npulse = 0;
        send_word(32'h0000_0001, 0);
        chk("b2b_first", bus.word_out, 32'h0000_0001);
        send_word(32'h8000_0000, 40);
        chk("b2b_second", bus.word_out, 32'h8000_0000);
        chk("b2b_pulses", 32'(npulse), 32'd2);

        // ---- frame_start restart after 17 ones ----
        npulse = 0;
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 31; i++) cyc(0, 0, 1, 1);
        chk("fs_word", bus.word_out, 32'h7FFF_FFFF);
        chk("fs_pulses", 32'(npulse), 32'd1);

        // ---- Reset mid-word ----
        npulse = 0;
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, $urandom_range(1));
        cyc(1, 0, 1, 1);
        chk("rst_word_cleared", bus.word_out, 32'h0);
        send_word(32'hDEAD_BEEF, 10);
        chk("rst_word_after", bus.word_out, 32'hDEAD_BEEF);
        chk("rst_pulses", 32'(npulse), 32'd1);

        // ---- Chained downstream register ----
        send_word(32'h1234_5678, 0);
        chk("chain_valid", {31'd0, bus.word_valid}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("chain_reg", data_out, 32'h1234_5678);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk("chain_reg_hold", data_out, 32'h1234_5678);

        // ---- Random stream against the model ----
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(499) == 0,
                $urandom_range(99) < 2,
                $urandom_range(99) < 75,
                $urandom_range(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
